pipe_reg_mem: RTL



---
 rtl/y86_pkg.sv | 35 +++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_reg_mem.sv | 123 ++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 constants: instruction codes, register IDs, status codes and
// the per-edge action taken by the Execute->Memory pipeline register.
package y86_pkg;

   // Instruction codes
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // "No register" ID
   localparam logic [3:0] RNONE = 4'hF;

   // Status codes
   localparam logic [3:0] SAOK = 4'h1;
   localparam logic [3:0] SHLT = 4'h2;
   localparam logic [3:0] SADR = 4'h3;
   localparam logic [3:0] SINS = 4'h4;

   // What the stage does on a given clock edge
   typedef enum logic [1:0] {
      ACT_HOLD   = 2'd0,   // frozen or stalled: keep contents
      ACT_BUBBLE = 2'd1,   // inject a NOP with clean fields
      ACT_LOAD   = 2'd2    // capture the Execute outputs
   } stage_act_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear and asynchronous reset.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   // Clear beats increment; the count sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_reg_mem.sv
// Execute->Memory pipeline register for the pipelined Y86 core, with stall,
// bubble, valid flag, optional freeze on exception and event counters.
module pipe_reg_mem
   import y86_pkg::*;
#(
   parameter int                  WORD_W        = 64,
   parameter int                  REG_W         = 4,
   parameter int                  ICODE_W       = 4,
   parameter int                  STAT_W        = 4,
   parameter logic [ICODE_W-1:0]  NOP_ICODE     = ICODE_W'(INOP),
   parameter logic [REG_W-1:0]    RNONE_ID      = REG_W'(RNONE),
   parameter logic [STAT_W-1:0]   STAT_AOK      = STAT_W'(SAOK),
   parameter bit                  FREEZE_ON_EXC = 1'b1,
   parameter int                  CNT_W         = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               M_stall,
   input  logic               M_bubble,
   input  logic               cnt_clr,
   input  logic [STAT_W-1:0]  E_stat,
   input  logic [ICODE_W-1:0] E_icode,
   input  logic               e_Cnd,
   input  logic [WORD_W-1:0]  e_ValE,
   input  logic [WORD_W-1:0]  E_ValA,
   input  logic [REG_W-1:0]   e_dstE,
   input  logic [REG_W-1:0]   E_dstM,
   output logic [STAT_W-1:0]  M_stat,
   output logic [ICODE_W-1:0] M_icode,
   output logic               M_Cnd,
   output logic [WORD_W-1:0]  M_ValE,
   output logic [WORD_W-1:0]  M_ValA,
   output logic [REG_W-1:0]   M_dstE,
   output logic [REG_W-1:0]   M_dstM,
   output logic               M_valid,
   output logic               M_exc,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   stall_cnt
);

   logic       frozen;
   stage_act_t act;

   assign M_exc  = (M_stat != STAT_AOK);
   assign frozen = FREEZE_ON_EXC && M_exc;

   // Resolve the edge action: frozen > bubble > stall > load.
   always_comb begin
      act = ACT_LOAD;
      if (frozen) begin
         act = ACT_HOLD;
      end else if (M_bubble) begin
         act = ACT_BUBBLE;
      end else if (M_stall) begin
         act = ACT_HOLD;
      end
   end

   // Pipeline fields; a bubble restores the full reset image so no stale data survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         M_stat  <= STAT_AOK;
         M_icode <= NOP_ICODE;
         M_Cnd   <= 1'b0;
         M_ValE  <= '0;
         M_ValA  <= '0;
         M_dstE  <= RNONE_ID;
         M_dstM  <= RNONE_ID;
         M_valid <= 1'b0;
      end else begin
         case (act)
            ACT_BUBBLE: begin
               M_stat  <= STAT_AOK;
               M_icode <= NOP_ICODE;
               M_Cnd   <= 1'b0;
               M_ValE  <= '0;
               M_ValA  <= '0;
               M_dstE  <= RNONE_ID;
               M_dstM  <= RNONE_ID;
               M_valid <= 1'b0;
            end
            ACT_LOAD: begin
               M_stat  <= E_stat;
               M_icode <= E_icode;
               M_Cnd   <= e_Cnd;
               M_ValE  <= e_ValE;
               M_ValA  <= E_ValA;
               M_dstE  <= e_dstE;
               M_dstM  <= E_dstM;
               M_valid <= 1'b1;
            end
            default: begin
               M_stat  <= M_stat;
               M_icode <= M_icode;
               M_Cnd   <= M_Cnd;
               M_ValE  <= M_ValE;
               M_ValA  <= M_ValA;
               M_dstE  <= M_dstE;
               M_dstM  <= M_dstM;
               M_valid <= M_valid;
            end
         endcase
      end
   end

   // A stall only counts when it actually held the stage (not frozen, not overridden by bubble).
   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk (clk),
      .rst (rst),
      .inc (act == ACT_BUBBLE),
      .clr (cnt_clr),
      .cnt (bubble_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (!frozen && !M_bubble && M_stall),
      .clr (cnt_clr),
      .cnt (stall_cnt)
   );

endmodule
